// File: rtl/sys_defs.sv
// Shared bus definitions for the fetch path: command encodings, address width
// and the default geometry of the instruction-memory responder.
package sys_defs;

  localparam int unsigned XLEN = 32;

  localparam int unsigned IMEM_LATENCY = 4;
  localparam int unsigned IMEM_DEPTH   = 1024;
  localparam int unsigned IMEM_NTAGS   = 15;
  localparam int unsigned TAG_W        = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_command_t;

endpackage

// File: rtl/imem_tag_table.sv
// Outstanding-request bookkeeping: lowest-free-tag encoder, per-tag countdowns
// and selection of the single entry due to complete on the next edge.
module imem_tag_table
  import sys_defs::*;
#(
  parameter int unsigned LATENCY = IMEM_LATENCY,
  parameter int unsigned NTAGS   = IMEM_NTAGS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc,
  input  logic             alloc_is_load,
  input  logic [63:0]      alloc_data,
  output logic [TAG_W-1:0] free_tag,
  output logic [TAG_W-1:0] due_tag,
  output logic [63:0]      due_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [NTAGS:1] busy;
  logic [NTAGS:1] is_load;
  logic [3:0]     count [1:NTAGS];
  logic [63:0]    data  [1:NTAGS];
  logic [NTAGS:1] due_vec;

  always_comb begin
    free_tag = '0;
    for (int unsigned i = NTAGS; i >= 1; i--) begin
      if (!busy[i]) free_tag = TAG_W'(i);
    end
  end

  // An entry sits on the output during the cycle its countdown is zero, so it
  // is selected one edge earlier (count==1); with LATENCY==1 that is the
  // allocation itself.
  always_comb begin
    due_tag  = '0;
    due_data = '0;
    for (int unsigned i = 1; i <= NTAGS; i++) begin
      due_vec[i] = busy[i] && (count[i] == 4'd1);
    end
    if (LATENCY == 1 && alloc) begin
      due_tag  = free_tag;
      due_data = alloc_is_load ? alloc_data : '0;
    end
    for (int unsigned i = 1; i <= NTAGS; i++) begin
      if (due_vec[i]) begin
        due_tag  = TAG_W'(i);
        due_data = is_load[i] ? data[i] : '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy    <= '0;
      is_load <= '0;
      for (int unsigned i = 1; i <= NTAGS; i++) begin
        count[i] <= '0;
        data[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 1; i <= NTAGS; i++) begin
        if (busy[i]) begin
          if (count[i] == 4'd0) busy[i] <= 1'b0;
          else                  count[i] <= count[i] - 4'd1;
        end
        if (alloc && free_tag == TAG_W'(i)) begin
          busy[i]    <= 1'b1;
          is_load[i] <= alloc_is_load;
          count[i]   <= CNT_INIT;
          data[i]    <= alloc_is_load ? alloc_data : '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert ($onehot0(due_vec));
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Tagged instruction-memory responder: grants a tag combinationally and
// returns load data with that tag a fixed number of cycles later.
module imem_responder
  import sys_defs::*;
#(
  parameter int unsigned LATENCY = IMEM_LATENCY,
  parameter int unsigned DEPTH   = IMEM_DEPTH,
  parameter int unsigned NTAGS   = IMEM_NTAGS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2mem_command,
  input  logic [XLEN-1:0]  proc2mem_addr,
  input  logic [63:0]      proc2mem_data,
  input  logic             force_reject,
  output logic [TAG_W-1:0] mem2proc_response,
  output logic [TAG_W-1:0] mem2proc_tag,
  output logic [63:0]      mem2proc_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [IDX_W-1:0] word_idx;
  logic             unused_addr;
  bus_command_t     cmd;
  logic             accept;
  logic [TAG_W-1:0] free_tag;
  logic [TAG_W-1:0] due_tag;
  logic [63:0]      due_data;

  assign word_idx    = proc2mem_addr[IDX_W+2:3];
  assign unused_addr = ^{proc2mem_addr[XLEN-1:IDX_W+3], proc2mem_addr[2:0]};

  always_comb begin
    case (proc2mem_command)
      2'b01:   cmd = BUS_LOAD;
      2'b10:   cmd = BUS_STORE;
      default: cmd = BUS_NONE;
    endcase
  end

  assign accept            = reset && !force_reject && (cmd != BUS_NONE) && (free_tag != '0);
  assign mem2proc_response = accept ? free_tag : '0;

  imem_tag_table #(
    .LATENCY (LATENCY),
    .NTAGS   (NTAGS)
  ) u_tag_table (
    .clock         (clock),
    .reset         (reset),
    .alloc         (accept),
    .alloc_is_load (cmd == BUS_LOAD),
    .alloc_data    (mem[word_idx]),
    .free_tag      (free_tag),
    .due_tag       (due_tag),
    .due_data      (due_data)
  );

  // Backing store survives reset by design.
  always_ff @(posedge clock) begin
    if (accept && cmd == BUS_STORE) mem[word_idx] <= proc2mem_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
    end else begin
      mem2proc_tag  <= due_tag;
      mem2proc_data <= due_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: two instances (latency 4 and 15) share
// stimulus; a per-instance scoreboard predicts grants and returns.
module tb_imem_responder;
  import sys_defs::*;

  localparam int NU   = 2;
  localparam int LAT1 = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cmd   = 2'b00;
  logic [31:0] addr  = '0;
  logic [63:0] wdata = '0;
  logic        frc   = 1'b0;

  logic [3:0]  rsp   [NU];
  logic [3:0]  tag   [NU];
  logic [63:0] rdata [NU];

  always #5 clock = ~clock;

  imem_responder u_dut4 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .force_reject      (frc),
    .mem2proc_response (rsp[0]),
    .mem2proc_tag      (tag[0]),
    .mem2proc_data     (rdata[0])
  );

  imem_responder #(.LATENCY(LAT1)) u_dut15 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .force_reject      (frc),
    .mem2proc_response (rsp[1]),
    .mem2proc_tag      (tag[1]),
    .mem2proc_data     (rdata[1])
  );

  typedef struct {
    int          ret;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  int          lat [NU] = '{4, LAT1};
  exp_t        sb [NU][$];
  int          free_at [NU][1:15];
  logic [63:0] mm [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  last_rsp  [NU];
  logic [3:0]  last_tag  [NU];
  logic [63:0] last_data [NU];

  function automatic logic [63:0] pat(int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i * 3)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // One cycle: drive inputs, check registered outputs and the grant, update model.
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                      input logic f, input logic r);
    exp_t e;
    int   etag;
    int   key;
    cmd = c; addr = a; wdata = d; frc = f; reset = r;
    #3;
    for (int u = 0; u < NU; u++) begin
      last_rsp[u]  = rsp[u];
      last_tag[u]  = tag[u];
      last_data[u] = rdata[u];
      if (sb[u].size() > 0 && sb[u][0].ret == cyc) begin
        e = sb[u].pop_front();
        check($sformatf("u%0d_ret_tag", u), {60'd0, tag[u]}, {60'd0, e.tag});
        check($sformatf("u%0d_ret_data", u), rdata[u], e.data);
      end else begin
        check($sformatf("u%0d_idle_tag", u), {60'd0, tag[u]}, 64'd0);
        check($sformatf("u%0d_idle_data", u), rdata[u], 64'd0);
      end
      etag = 0;
      if (r && !f && (c == 2'b01 || c == 2'b10)) begin
        for (int t = 15; t >= 1; t--) begin
          if (free_at[u][t] <= cyc) etag = t;
        end
      end
      check($sformatf("u%0d_response", u), {60'd0, rsp[u]}, 64'(etag));
      if (etag != 0) begin
        key = u * 4096 + int'((a >> 3) & 32'd1023);
        free_at[u][etag] = cyc + lat[u] + 1;
        e.ret = cyc + lat[u];
        e.tag = 4'(etag);
        if (c == 2'b10) begin
          mm[key] = d;
          e.data  = '0;
        end else begin
          e.data = mm.exists(key) ? mm[key] : 64'd0;
        end
        sb[u].push_back(e);
      end
      if (!r) begin
        sb[u].delete();
        for (int t = 1; t <= 15; t++) free_at[u][t] = 0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(BUS_NONE, 32'd0, 64'd0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int u = 0; u < NU; u++)
      for (int t = 1; t <= 15; t++) free_at[u][t] = 0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state: outputs zero, a load during reset gets no grant.
    step(BUS_LOAD, 32'h40, 64'd0, 1'b0, 1'b0);
    check("reset_rsp", {60'd0, last_rsp[0]}, 64'd0);

    // Preload words 1..15 so later loads have known data.
    for (int i = 1; i <= 15; i++) step(BUS_STORE, 32'(i * 8), pat(i), 1'b0, 1'b1);
    idle(16);

    // Single load of word 8; tag 1 stays busy in its return cycle.
    step(BUS_LOAD, 32'h40, 64'd0, 1'b0, 1'b1);
    check("t1_first_grant", {60'd0, last_rsp[0]}, 64'd1);
    idle(3);
    step(BUS_LOAD, 32'h48, 64'd0, 1'b0, 1'b1);
    check("t1_ret_tag", {60'd0, last_tag[0]}, 64'd1);
    check("t1_ret_data", last_data[0], pat(8));
    check("t1_busy_in_ret", {60'd0, last_rsp[0]}, 64'd2);
    step(BUS_LOAD, 32'h50, 64'd0, 1'b0, 1'b1);
    check("t1_regrant", {60'd0, last_rsp[0]}, 64'd1);
    idle(16);

    // Store then load of the same word on consecutive cycles.
    step(BUS_STORE, 32'h100, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1);
    check("t2_store_grant", {60'd0, last_rsp[0]}, 64'd1);
    step(BUS_LOAD, 32'h100, 64'd0, 1'b0, 1'b1);
    check("t2_load_grant", {60'd0, last_rsp[0]}, 64'd2);
    idle(2);
    step(BUS_NONE, 32'd0, 64'd0, 1'b0, 1'b1);
    check("t2_store_ret_tag", {60'd0, last_tag[0]}, 64'd1);
    check("t2_store_ret_data", last_data[0], 64'd0);
    step(BUS_NONE, 32'd0, 64'd0, 1'b0, 1'b1);
    check("t2_load_ret_tag", {60'd0, last_tag[0]}, 64'd2);
    check("t2_load_ret_data", last_data[0], 64'hDEADBEEF_CAFEF00D);
    idle(16);

    // Fill all 15 tags of the latency-15 instance; full even while tag 1 returns.
    for (int i = 0; i < 15; i++) begin
      step(BUS_LOAD, 32'((i + 1) * 8), 64'd0, 1'b0, 1'b1);
      check("t3_fill_grant", {60'd0, last_rsp[1]}, 64'(i + 1));
    end
    step(BUS_LOAD, 32'h8, 64'd0, 1'b0, 1'b1);
    check("t3_full_reject", {60'd0, last_rsp[1]}, 64'd0);
    check("t3_full_ret_tag", {60'd0, last_tag[1]}, 64'd1);
    step(BUS_LOAD, 32'h10, 64'd0, 1'b0, 1'b1);
    check("t3_regrant", {60'd0, last_rsp[1]}, 64'd1);
    idle(17);

    // Address wrap: DEPTH*8 aliases word 0.
    step(BUS_STORE, 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    step(BUS_LOAD, 32'h2000, 64'd0, 1'b0, 1'b1);
    idle(3);
    step(BUS_NONE, 32'd0, 64'd0, 1'b0, 1'b1);
    check("t4_wrap_tag", {60'd0, last_tag[0]}, 64'd2);
    check("t4_wrap_data", last_data[0], 64'h0123_4567_89AB_CDEF);
    idle(17);

    // force_reject blocks every command; nothing returns.
    repeat (3) begin
      step(BUS_LOAD, 32'h40, 64'd0, 1'b1, 1'b1);
      check("t5_forced_u0", {60'd0, last_rsp[0]}, 64'd0);
      check("t5_forced_u1", {60'd0, last_rsp[1]}, 64'd0);
    end
    idle(17);
    step(BUS_LOAD, 32'h40, 64'd0, 1'b0, 1'b1);
    check("t5_after_release", {60'd0, last_rsp[0]}, 64'd1);
    idle(17);

    // Reset two cycles after acceptance drops the request silently.
    step(BUS_LOAD, 32'h40, 64'd0, 1'b0, 1'b1);
    idle(1);
    step(BUS_NONE, 32'd0, 64'd0, 1'b0, 1'b0);
    idle(1);
    step(BUS_NONE, 32'd0, 64'd0, 1'b0, 1'b1);
    check("t6_dropped_tag", {60'd0, last_tag[0]}, 64'd0);
    idle(2);
    step(BUS_LOAD, 32'h48, 64'd0, 1'b0, 1'b1);
    check("t6_post_reset_grant", {60'd0, last_rsp[0]}, 64'd1);
    idle(17);

    // Unknown encoding behaves as no command.
    step(2'b11, 32'h40, 64'd0, 1'b0, 1'b1);
    check("t7_unknown_cmd", {60'd0, last_rsp[0]}, 64'd0);
    idle(17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
